// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared types, widths and helpers for the display arbiter.
package disp_arb_pkg;

  localparam int unsigned BCD_W   = 24;
  localparam int unsigned DIGITS  = 6;
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [3:0]       BLANK_CODE = 4'hF;
  localparam logic [BCD_W-1:0] BLANK_WORD = {DIGITS{BLANK_CODE}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] src_idx_t;

  // Payload presented to the display controller.
  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             dp;
  } disp_word_t;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic src_idx_t highest_set(input logic [MAX_SRC-1:0] v);
    src_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // One-hot vector for a source index.
  function automatic logic [MAX_SRC-1:0] one_hot(input src_idx_t idx);
    return MAX_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/disp_arb_if.sv
// disp_arb_if: source-side inputs and display-side outputs of the arbiter.
interface disp_arb_if #(
  parameter int unsigned NUM_SRC = 3
) ();

  logic [NUM_SRC-1:0]                      req_in;
  logic [NUM_SRC*disp_arb_pkg::BCD_W-1:0]  src_data_in;
  logic [NUM_SRC-1:0]                      src_dp_in;
  logic [disp_arb_pkg::BCD_W-1:0]          bcd_data_out;
  logic                                    dp_out;
  logic [NUM_SRC-1:0]                      grant_out;
  logic                                    busy_out;

  // Sources and display consumer side.
  modport master (
    output req_in, src_data_in, src_dp_in,
    input  bcd_data_out, dp_out, grant_out, busy_out
  );

  // Arbiter side.
  modport slave (
    input  req_in, src_data_in, src_dp_in,
    output bcd_data_out, dp_out, grant_out, busy_out
  );

endinterface

// File: rtl/disp_hold_timer.sv
// disp_hold_timer: cycle counter that flags its last count; used for the
// hold time and for the blank gap.
module disp_hold_timer #(
  parameter int unsigned TERM_CNT = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done_c
);

  localparam int unsigned CNT_W = (TERM_CNT > 1) ? $clog2(TERM_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM_CNT - 1);

  logic [CNT_W-1:0] count_q;

  // Count while enabled, park on the last value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !done_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Terminal count reached.
  always_comb begin
    done_c = (count_q == LAST);
  end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the six-digit display between NUM_SRC BCD sources.
// Source 0 is the default owner; higher sources take the display on a
// request pulse for HOLD_TIME_MS, higher index wins.
// Optional: define DISP_ARB_BLANK_GAP_EN to insert a one-millisecond blank
// gap before every owner change.
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned HOLD_TIME_MS = 2000,
  parameter int unsigned NUM_SRC      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_arb_if.slave  bus
);

  localparam int unsigned CYCLES_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned HOLD_CYCLES   = HOLD_TIME_MS * CYCLES_PER_MS;

  state_e             state_q;
  src_idx_t           owner_q;
  logic [NUM_SRC-1:0] grant_q;
  logic               busy_q;
  disp_word_t         disp_q;

  logic [BCD_W-1:0]   src_word [MAX_SRC];
  logic [MAX_SRC-1:0] dp_ext;
  logic [MAX_SRC-1:0] req_ext;
  logic               any_req_c;
  src_idx_t           win_c;
  logic               qualify_c;
  logic               hold_done_c;

  // Unpack the source bus; unused slots read as zero.
  for (genvar k = 0; k < MAX_SRC; k++) begin : g_src
    if (k < NUM_SRC) begin : g_used
      assign src_word[k] = bus.src_data_in[k*BCD_W +: BCD_W];
    end else begin : g_unused
      assign src_word[k] = '0;
    end
  end

  assign dp_ext = MAX_SRC'(bus.src_dp_in);

  // Winner among sources 1..N-1; it qualifies if it is not below the
  // current (or pending) owner, which also covers retrigger.
  always_comb begin
    req_ext   = MAX_SRC'(bus.req_in) & ~MAX_SRC'(1);
    any_req_c = |req_ext;
    win_c     = highest_set(req_ext);
    qualify_c = any_req_c && (win_c >= owner_q);
  end

  disp_hold_timer #(
    .TERM_CNT (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_q != HOLD) || qualify_c),
    .enable (state_q == HOLD),
    .done_c (hold_done_c)
  );

`ifdef DISP_ARB_BLANK_GAP_EN
  logic blank_done_c;

  disp_hold_timer #(
    .TERM_CNT (CYCLES_PER_MS)
  ) u_blank_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_q != BLANK) || qualify_c),
    .enable (state_q == BLANK),
    .done_c (blank_done_c)
  );

  // Ownership FSM with a blank gap; owner_q holds the pending owner in BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= NUM_SRC'(1);
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        BLANK: begin
          if (qualify_c) begin
            owner_q <= win_c;
          end else if (blank_done_c) begin
            state_q <= (owner_q == '0) ? IDLE : HOLD;
            grant_q <= NUM_SRC'(one_hot(owner_q));
            busy_q  <= (owner_q != '0);
          end
        end
        default: begin
          if (qualify_c) begin
            state_q <= BLANK;
            owner_q <= win_c;
            grant_q <= '0;
          end else if ((state_q == HOLD) && hold_done_c) begin
            state_q <= BLANK;
            owner_q <= '0;
            grant_q <= '0;
          end
        end
      endcase
    end
  end
`else
  // Ownership FSM switching owners directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= NUM_SRC'(1);
      busy_q  <= 1'b0;
    end else begin
      if (qualify_c) begin
        state_q <= HOLD;
        owner_q <= win_c;
        grant_q <= NUM_SRC'(one_hot(win_c));
        busy_q  <= 1'b1;
      end else if ((state_q == HOLD) && hold_done_c) begin
        state_q <= IDLE;
        owner_q <= '0;
        grant_q <= NUM_SRC'(1);
        busy_q  <= 1'b0;
      end
    end
  end
`endif

  // Registered mux of the current owner's live data, blank code in a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (state_q == BLANK) begin
      disp_q <= '{bcd: BLANK_WORD, dp: 1'b0};
    end else begin
      disp_q <= '{bcd: src_word[owner_q], dp: dp_ext[owner_q]};
    end
  end

  assign bus.grant_out    = grant_q;
  assign bus.busy_out     = busy_q;
  assign bus.bcd_data_out = disp_q.bcd;
  assign bus.dp_out       = disp_q.dp;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed bench with a deadline-based ownership model.
// Honours DISP_ARB_BLANK_GAP_EN when the design is built with it.
module tb_disp_arbiter;

  localparam int unsigned NS = 3;
  localparam int HT = 30;
`ifdef DISP_ARB_BLANK_GAP_EN
  localparam int GAP = 10;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  disp_arb_if #(.NUM_SRC(NS)) bus ();

  disp_arbiter #(
    .CLK_FREQ_HZ  (10_000),
    .HOLD_TIME_MS (3),
    .NUM_SRC      (NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who is on screen (-1 = blank), who the next owner is, and the
  // absolute edge numbers at which the gap or hold ends.
  int shown, target, busy_m, gap_end, deadline, e;
  logic [2:0]  exp_grant;
  logic        exp_busy, exp_dp;
  logic [23:0] exp_bcd;

  always @(posedge clk or negedge rst_n) begin
    int w;
    logic [71:0] d;
    logic [2:0]  dpv;
    if (!rst_n) begin
      e = 0; shown = 0; target = 0; busy_m = 0; gap_end = 0; deadline = 0;
      exp_grant = 3'b001; exp_busy = 1'b0; exp_bcd = 24'h0; exp_dp = 1'b0;
    end else begin
      e++;
      d   = bus.src_data_in;
      dpv = bus.src_dp_in;
      if (shown < 0) begin
        exp_bcd = 24'hFFFFFF;
        exp_dp  = 1'b0;
      end else begin
        exp_bcd = 24'(d >> (shown * 24));
        exp_dp  = 1'(dpv >> shown);
      end
      w = 0;
      for (int i = 1; i < NS; i++) if (bus.req_in[i]) w = i;
      if (w > 0 && w >= target) begin
        target = w;
        if (GAP == 0) begin shown = w; busy_m = 1; deadline = e + HT; end
        else begin shown = -1; gap_end = e + GAP; end
      end else if (shown < 0 && e == gap_end) begin
        shown = target; busy_m = (target != 0) ? 1 : 0; deadline = e + HT;
      end else if (shown > 0 && e == deadline) begin
        target = 0;
        if (GAP == 0) begin shown = 0; busy_m = 0; end
        else begin shown = -1; gap_end = e + GAP; end
      end
      exp_grant = (shown < 0) ? 3'b000 : 3'(1 << shown);
      exp_busy  = (busy_m != 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_grant", 32'(bus.grant_out), 32'(exp_grant));
      check("model_busy",  32'(bus.busy_out),  32'(exp_busy));
      check("model_bcd",   32'(bus.bcd_data_out), 32'(exp_bcd));
      check("model_dp",    32'(bus.dp_out),    32'(exp_dp));
    end
  end

  // Drive a one-cycle request; returns at the negedge where the result shows.
  task automatic pulse(input logic [2:0] r);
    bus.req_in = r;
    @(negedge clk);
    bus.req_in = 3'b000;
  endtask

  // Negedges until grant_out equals g, bounded.
  task automatic wait_grant(input logic [2:0] g, output int n);
    n = 0;
    while (bus.grant_out !== g && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [2:0] tbl_req [6] = '{3'b010, 3'b100, 3'b010, 3'b110, 3'b100, 3'b000};
  int         tbl_gap [6] = '{3, 12, 40, 35, 5, 45};

  initial begin
    int n;
    rst_n = 1'b0;
    bus.req_in = 3'b000;
    bus.src_data_in = {24'h222222, 24'h111111, 24'h012345};
    bus.src_dp_in = 3'b010;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant_out), 32'h1);
    check("rst_busy",  32'(bus.busy_out), 32'h0);
    check("rst_bcd",   32'(bus.bcd_data_out), 32'h0);
    check("rst_dp",    32'(bus.dp_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_bcd",   32'(bus.bcd_data_out), 32'h012345);
    check("idle_grant", 32'(bus.grant_out), 32'h1);
    bus.src_data_in[23:0] = 24'h012346;
    @(negedge clk);
    check("live_follow", 32'(bus.bcd_data_out), 32'h012346);

`ifndef DISP_ARB_BLANK_GAP_EN
    pulse(3'b010);
    check("grant1", 32'(bus.grant_out), 32'h2);
    check("busy1",  32'(bus.busy_out), 32'h1);
    @(negedge clk);
    check("bcd1", 32'(bus.bcd_data_out), 32'h111111);
    wait_grant(3'b001, n);
    check("hold_len", 32'(1 + n), 32'd30);

    pulse(3'b010);
    repeat (10) @(negedge clk);
    pulse(3'b010);
    check("retrig_owner", 32'(bus.grant_out), 32'h2);
    wait_grant(3'b001, n);
    check("retrig_len", 32'(n), 32'd30);

    pulse(3'b100);
    repeat (5) @(negedge clk);
    pulse(3'b010);
    check("low_drop", 32'(bus.grant_out), 32'h4);
    wait_grant(3'b001, n);
    check("low_drop_len", 32'(n), 32'd24);

    pulse(3'b010);
    repeat (5) @(negedge clk);
    pulse(3'b100);
    check("preempt", 32'(bus.grant_out), 32'h4);
    wait_grant(3'b001, n);
    check("preempt_len", 32'(n), 32'd30);

    pulse(3'b110);
    check("simul_win",  32'(bus.grant_out), 32'h4);
    check("simul_busy", 32'(bus.busy_out), 32'h1);
    repeat (29) @(negedge clk);
    pulse(3'b100);
    check("expiry_req", 32'(bus.grant_out), 32'h4);
    wait_grant(3'b001, n);
    check("expiry_req_len", 32'(n), 32'd30);

    pulse(3'b010);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(bus.grant_out), 32'h1);
    check("arst_busy",  32'(bus.busy_out), 32'h0);
    check("arst_bcd",   32'(bus.bcd_data_out), 32'h0);
    check("arst_dp",    32'(bus.dp_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", 32'(bus.grant_out), 32'h1);
`else
    pulse(3'b010);
    check("gap_grant", 32'(bus.grant_out), 32'h0);
    check("gap_busy",  32'(bus.busy_out), 32'h0);
    @(negedge clk);
    check("gap_bcd", 32'(bus.bcd_data_out), 32'hFFFFFF);
    wait_grant(3'b010, n);
    check("gap_len", 32'(1 + n), 32'd10);
    wait_grant(3'b000, n);
    check("gap_hold_len", 32'(n), 32'd30);
    check("gap_busy_keep", 32'(bus.busy_out), 32'h1);
    wait_grant(3'b001, n);
    check("gap_exit_len", 32'(n), 32'd10);

    pulse(3'b010);
    repeat (3) @(negedge clk);
    pulse(3'b100);
    check("gap_preempt", 32'(bus.grant_out), 32'h0);
    wait_grant(3'b100, n);
    check("gap_restart", 32'(n), 32'd10);
    wait_grant(3'b000, n);
    check("gap_hold2", 32'(n), 32'd30);
    wait_grant(3'b001, n);
    check("gap_exit2", 32'(n), 32'd10);
`endif

    for (int i = 0; i < 6; i++) begin
      bus.src_data_in[47:24] = 24'h111100 + 24'(i);
      bus.src_data_in[71:48] = 24'h222200 + 24'(i);
      bus.src_dp_in = 3'(i + 1);
      pulse(tbl_req[i]);
      repeat (tbl_gap[i]) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
